// File: rtl/tdm_demux.sv
// TDM demultiplexer: rebuilds N_LANES-bit frames from a serial
// stream, using a frame-sync marker and a lock state machine.
module tdm_demux #(
  parameter int N_LANES = 4,
  localparam int SLOT_W = $clog2(N_LANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               valid,
  input  logic               sync,
  output logic [N_LANES-1:0] y,
  output logic               y_valid,
  output logic [SLOT_W-1:0]  slot,
  output logic               locked,
  output logic               sync_err
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(N_LANES - 1);

  state_t               state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [N_LANES-2:0]   shadow_q, shadow_d;
  logic [N_LANES-1:0]   y_q, y_d;
  logic                 yv_d, err_d;

  // Next-state, slot tracking, shadow capture and frame output.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    yv_d     = 1'b0;
    err_d    = 1'b0;
    if (valid) begin
      unique case (state_q)
        UNLOCKED: begin
          if (sync) begin
            shadow_d[0] = din;
            slot_d      = SLOT_W'(1);
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            err_d       = (slot_q != '0);
            shadow_d[0] = din;
            slot_d      = SLOT_W'(1);
          end else if (slot_q == '0) begin
            err_d   = 1'b1;
            state_d = UNLOCKED;
          end else if (slot_q == LAST) begin
            y_d    = {din, shadow_q};
            yv_d   = 1'b1;
            slot_d = '0;
          end else begin
            for (int k = 1; k < N_LANES - 1; k++) begin
              if (slot_q == SLOT_W'(k)) shadow_d[k] = din;
            end
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // State, counter, shadow and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= UNLOCKED;
      slot_q   <= '0;
      shadow_q <= '0;
      y_q      <= '0;
      y_valid  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      y_valid  <= yv_d;
      sync_err <= err_d;
    end
  end

  assign y      = y_q;
  assign slot   = slot_q;
  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized and directed check of tdm_demux against a
// frame-level reference model.
module tb_tdm_demux;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, din, valid, sync;
  logic [N-1:0] y;
  logic         y_valid, locked, sync_err;
  logic [1:0]   slot;

  int checks = 0;
  int errors = 0;
  int yv_count = 0;

  bit       m_locked;
  int       m_pos;
  bit [N-1:0] m_frame, m_y;
  bit       m_yv, m_err;

  tdm_demux #(.N_LANES(N)) dut (
    .clk(clk), .rst(rst), .din(din), .valid(valid),
    .sync(sync), .y(y), .y_valid(y_valid), .slot(slot),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input bit r, input bit v,
                       input bit s, input bit d);
    m_yv  = 0;
    m_err = 0;
    if (r) begin
      m_locked = 0;
      m_pos    = 0;
      m_y      = '0;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_frame[0] = d;
          m_pos = 1;
          m_locked = 1;
        end
      end else if (s) begin
        m_err = (m_pos != 0);
        m_frame[0] = d;
        m_pos = 1;
      end else if (m_pos == 0) begin
        m_err = 1;
        m_locked = 0;
      end else begin
        m_frame[m_pos] = d;
        m_pos++;
        if (m_pos == N) begin
          m_y = m_frame;
          m_yv = 1;
          m_pos = 0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit v,
                      input bit s, input bit d);
    @(negedge clk);
    rst = r; valid = v; sync = s; din = d;
    @(posedge clk);
    model(r, v, s, d);
    #1;
    check("y", 32'(y), 32'(m_y));
    check("y_valid", 32'(y_valid), 32'(m_yv));
    check("slot", 32'(slot), 32'(m_pos));
    check("locked", 32'(locked), 32'(m_locked));
    check("sync_err", 32'(sync_err), 32'(m_err));
    if (y_valid) yv_count++;
  endtask

  task automatic beat(input bit s, input bit d);
    step(0, 1, s, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 1'($urandom), 1'($urandom));
  endtask

  initial begin
    int cnt0;
    rst = 1; valid = 0; sync = 0; din = 0;
    // reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), 1'($urandom), 1'($urandom));
    check("rst_y", 32'(y), 0);
    check("rst_locked", 32'(locked), 0);
    // clean frames
    beat(1, 1);
    check("lock_after_first", 32'(locked), 1);
    beat(0, 0); beat(0, 1); beat(0, 1);
    check("frame1_y", 32'(y), 32'h0000000d);
    check("frame1_yv", 32'(y_valid), 1);
    beat(1, 0); beat(0, 1); beat(0, 1); beat(0, 0);
    check("frame2_y", 32'(y), 32'h00000006);
    // gaps
    cnt0 = yv_count;
    beat(1, 1); idle(3);
    check("gap_slot", 32'(slot), 1);
    beat(0, 0); idle(3);
    beat(0, 1); idle(3);
    beat(0, 1); idle(3);
    check("gap_y", 32'(y), 32'h0000000d);
    check("gap_pulses", 32'(yv_count - cnt0), 1);
    // early sync
    beat(1, 1); beat(0, 1);
    beat(1, 0);
    check("early_err", 32'(sync_err), 1);
    check("early_y_hold", 32'(y), 32'h0000000d);
    beat(0, 0); beat(0, 1); beat(0, 1);
    check("early_y", 32'(y), 32'h0000000c);
    check("early_locked", 32'(locked), 1);
    // missing sync
    beat(0, 1);
    check("miss_err", 32'(sync_err), 1);
    check("miss_unlock", 32'(locked), 0);
    beat(0, 1); beat(0, 0); beat(0, 1);
    check("unlocked_slot", 32'(slot), 0);
    beat(1, 1);
    check("relock", 32'(locked), 1);
    // reset mid-frame
    beat(0, 1);
    step(1, 0, 0, 0);
    check("midrst_y", 32'(y), 0);
    check("midrst_slot", 32'(slot), 0);
    beat(0, 1); beat(0, 0);
    check("midrst_ignored", 32'(locked), 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, v, s;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (m_pos == 0)
        s = ($urandom_range(0, 9) != 0);
      else
        s = ($urandom_range(0, 11) == 0);
      step(r, v, s, 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
